alu_control_md: RTL and testbench

//  Second-generation ALU control for the MIPS-32 core. Decodes ALU_Op/Funct into a
//  4-bit ALU_Control code (superset of the legacy 3-bit codes) with zero latency.

---
 rtl/alu_ctrl_pkg.sv | 62 ++++++
 rtl/alu_control_md_datapath.sv | 104 ++++++++++
 rtl/alu_control_md.sv | 130 +++++++++++++
 tb/tb_alu_control_md.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the MIPS-32 ALU control / multiply-divide block.
// Holds the ALU_Control operation codes, the ALU_Op classes, the Funct field
// encodings, the sequencer state enum and the multiply/divide op enum.
package alu_ctrl_pkg;

    // ALU_Control codes; the low 3 bits match the legacy 3-bit codes.
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;
    localparam logic [3:0] ALU_SRA  = 4'b1010;
    localparam logic [3:0] ALU_SLTU = 4'b1011;
    localparam logic [3:0] ALU_NOR  = 4'b1100;

    // ALU_Op classes from the main decoder.
    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_SUB   = 2'b01;
    localparam logic [1:0] OP_RTYPE = 2'b10;
    localparam logic [1:0] OP_OR    = 2'b11;

    // Funct encodings.
    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_SRA   = 6'b000011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_ADDU  = 6'b100001;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SUBU  = 6'b100011;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIXUP} md_state_t;

    // Encoding equals Funct[1:0] of the mult/multu/div/divu group.
    typedef enum logic [1:0] {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU} md_op_t;

    // True for the eight Funct codes that touch HI/LO.
    function automatic logic is_md_funct(input logic [5:0] f);
        case (f)
            F_MFHI, F_MTHI, F_MFLO, F_MTLO,
            F_MULT, F_MULTU, F_DIV, F_DIVU: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_control_md_datapath.sv
// Iterative multiply/divide datapath.
// load  : capture operand magnitudes (signed ops) or raw operands, sign flags
//         and the divide-by-zero flag.
// step  : one shift-add (mult) or restoring-subtract (div) iteration.
// res_hi/res_lo : combinational, sign-corrected results; valid after WIDTH steps.
// Ports: clk, reset, load, step, op, rs_val, rt_val -> res_hi, res_lo.
module md_datapath
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  md_op_t           op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    // prod holds {partial product, multiplier} for mult and
    // {remainder, dividend/quotient} for div, so one register serves both.
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   m;        // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   raw_rs;   // original dividend for divide-by-zero
    logic               neg_q;    // product / quotient must be negated
    logic               neg_r;    // remainder must be negated
    logic               is_div;
    logic               dz;

    logic               sgn_op, sa, sb, ld_div;
    logic [WIDTH-1:0]   abs_rs, abs_rt;

    always_comb begin
        sgn_op = (op == MD_MULT) || (op == MD_DIV);
        ld_div = (op == MD_DIV) || (op == MD_DIVU);
        sa     = sgn_op & rs_val[WIDTH-1];
        sb     = sgn_op & rt_val[WIDTH-1];
        abs_rs = sa ? -rs_val : rs_val;
        abs_rt = sb ? -rt_val : rt_val;
    end

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     shifted, diff;
    logic [2*WIDTH-1:0] div_next;

    always_comb begin
        mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, m} : '0);
        mul_next = {mul_sum, prod[WIDTH-1:1]};
        // Remainder stays below the divisor, so the shifted value fits WIDTH+1
        // bits and diff[WIDTH] is a clean borrow flag.
        shifted  = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
        diff     = shifted - {1'b0, m};
        if (!diff[WIDTH])
            div_next = {diff[WIDTH-1:0], prod[WIDTH-2:0], 1'b1};
        else
            div_next = {shifted[WIDTH-1:0], prod[WIDTH-2:0], 1'b0};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prod   <= '0;
            m      <= '0;
            raw_rs <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            is_div <= 1'b0;
            dz     <= 1'b0;
        end else if (load) begin
            prod   <= {{WIDTH{1'b0}}, (ld_div ? abs_rs : abs_rt)};
            m      <= ld_div ? abs_rt : abs_rs;
            raw_rs <= rs_val;
            neg_q  <= sa ^ sb;
            neg_r  <= sa;
            is_div <= ld_div;
            dz     <= ld_div && (rt_val == '0);
        end else if (step) begin
            prod   <= is_div ? div_next : mul_next;
        end
    end

    logic [2*WIDTH-1:0] mul_res;
    logic [WIDTH-1:0]   q, r;

    always_comb begin
        mul_res = neg_q ? -prod : prod;
        q       = prod[WIDTH-1:0];
        r       = prod[2*WIDTH-1:WIDTH];
        if (dz) begin
            res_lo = '1;
            res_hi = raw_rs;
        end else if (is_div) begin
            res_lo = neg_q ? -q : q;
            res_hi = neg_r ? -r : r;
        end else begin
            res_lo = mul_res[WIDTH-1:0];
            res_hi = mul_res[2*WIDTH-1:WIDTH];
        end
    end

endmodule

// File: rtl/alu_control_md.sv
// ALU control with multiply/divide sequencer for the MIPS-32 core.
// Decodes ALU_Op/Funct into ALU_Control with zero latency, runs iterative
// mult/multu/div/divu (WIDTH steps plus one fix-up cycle), owns HI/LO
// (also written by mthi/mtlo) and raises stall for HI/LO-class instructions
// while the sequencer is busy.
// Ports: clk, reset (sync, active-high), ALU_Op, Funct, issue, rs_val, rt_val
//        -> ALU_Control, stall, md_busy, md_done, hi, lo.
module alu_control_md
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        ALU_Op,
    input  logic [5:0]        Funct,
    input  logic              issue,
    input  logic [WIDTH-1:0]  rs_val,
    input  logic [WIDTH-1:0]  rt_val,
    output logic [CTRL_W-1:0] ALU_Control,
    output logic              stall,
    output logic              md_busy,
    output logic              md_done,
    output logic [WIDTH-1:0]  hi,
    output logic [WIDTH-1:0]  lo
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    // ---------------- decode ----------------
    logic [3:0] ctrl_code;

    always_comb begin
        ctrl_code = ALU_AND;
        case (ALU_Op)
            OP_ADD: ctrl_code = ALU_ADD;
            OP_SUB: ctrl_code = ALU_SUB;
            OP_OR:  ctrl_code = ALU_OR;
            default: begin
                case (Funct)
                    F_AND:          ctrl_code = ALU_AND;
                    F_OR:           ctrl_code = ALU_OR;
                    F_ADD, F_ADDU:  ctrl_code = ALU_ADD;
                    F_SUB, F_SUBU:  ctrl_code = ALU_SUB;
                    F_SLT:          ctrl_code = ALU_SLT;
                    F_SLTU:         ctrl_code = ALU_SLTU;
                    F_XOR:          ctrl_code = ALU_XOR;
                    F_NOR:          ctrl_code = ALU_NOR;
                    F_SLL:          ctrl_code = ALU_SLL;
                    F_SRL:          ctrl_code = ALU_SRL;
                    F_SRA:          ctrl_code = ALU_SRA;
                    default:        ctrl_code = ALU_AND;
                endcase
            end
        endcase
    end

    assign ALU_Control = CTRL_W'(ctrl_code);

    // ---------------- interlock ----------------
    md_state_t        state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic             md_class, accept, start, wr_hi, wr_lo;

    assign md_class = (ALU_Op == OP_RTYPE) && is_md_funct(Funct);
    assign md_busy  = (state != ST_IDLE);
    assign stall    = issue & md_class & md_busy;
    // accept implies IDLE, so start never disturbs a running operation.
    assign accept   = issue & md_class & ~stall;
    assign start    = accept && (Funct[5:2] == F_MULT[5:2]);
    assign wr_hi    = accept && (Funct == F_MTHI);
    assign wr_lo    = accept && (Funct == F_MTLO);

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (start) state_nx = ST_RUN;
            ST_RUN:   if (cnt == CNT_W'(WIDTH - 1)) state_nx = ST_FIXUP;
            ST_FIXUP: state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)                cnt <= '0;
        else if (start)           cnt <= '0;
        else if (state == ST_RUN) cnt <= cnt + 1'b1;
    end

    // ---------------- datapath ----------------
    logic [WIDTH-1:0] res_hi, res_lo;

    md_datapath #(.WIDTH(WIDTH)) u_dp (
        .clk    (clk),
        .reset  (reset),
        .load   (start),
        .step   (state == ST_RUN),
        .op     (md_op_t'(Funct[1:0])),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .res_hi (res_hi),
        .res_lo (res_lo)
    );

    // ---------------- HI/LO ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            hi      <= '0;
            lo      <= '0;
            md_done <= 1'b0;
        end else begin
            md_done <= (state == ST_FIXUP);
            if (state == ST_FIXUP) begin
                hi <= res_hi;
                lo <= res_lo;
            end else begin
                if (wr_hi) hi <= rs_val;
                if (wr_lo) lo <= rs_val;
            end
        end
    end

endmodule

// File: tb/tb_alu_control_md.sv
// Bench for alu_control_md: WIDTH=32 and WIDTH=8 instances. Directed vectors
// push expected {hi, lo, busy cycles} into per-instance queues; monitors pop
// and compare on every md_done pulse.
module tb_alu_control_md;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  alu_op;
    logic [5:0]  funct;
    logic        issue, issue8;
    logic [31:0] rs, rt;
    logic [7:0]  rs8, rt8;

    logic [3:0]  ctrl, ctrl8;
    logic        stall, stall8, busy, busy8, done, done8;
    logic [31:0] hi, lo;
    logic [7:0]  hi8, lo8;

    always #5 clk = ~clk;

    alu_control_md #(.WIDTH(32), .CTRL_W(4)) u_dut (
        .clk(clk), .reset(reset), .ALU_Op(alu_op), .Funct(funct), .issue(issue),
        .rs_val(rs), .rt_val(rt), .ALU_Control(ctrl), .stall(stall),
        .md_busy(busy), .md_done(done), .hi(hi), .lo(lo)
    );

    alu_control_md #(.WIDTH(8), .CTRL_W(4)) u_dut8 (
        .clk(clk), .reset(reset), .ALU_Op(alu_op), .Funct(funct), .issue(issue8),
        .rs_val(rs8), .rt_val(rt8), .ALU_Control(ctrl8), .stall(stall8),
        .md_busy(busy8), .md_done(done8), .hi(hi8), .lo(lo8)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          busy;
    } exp_t;

    exp_t q32[$];
    exp_t q8[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- monitors ----------------
    int   bc32 = 0, bc8 = 0;
    logic pd32 = 1'b0, pd8 = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            bc32 = 0; pd32 = 1'b0; q32.delete();
        end else begin
            if (busy) bc32++;
            if (done) begin
                chk("done_pulse32", {31'b0, pd32}, 32'd0);
                chk("sb32_pending", 32'(q32.size() != 0), 32'd1);
                if (q32.size() != 0) begin
                    e = q32.pop_front();
                    chk("hi32", hi, e.hi);
                    chk("lo32", lo, e.lo);
                    chk("busy32", bc32, e.busy);
                end
                bc32 = 0;
            end
            pd32 = done;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            bc8 = 0; pd8 = 1'b0; q8.delete();
        end else begin
            if (busy8) bc8++;
            if (done8) begin
                chk("done_pulse8", {31'b0, pd8}, 32'd0);
                chk("sb8_pending", 32'(q8.size() != 0), 32'd1);
                if (q8.size() != 0) begin
                    e = q8.pop_front();
                    chk("hi8", {24'b0, hi8}, e.hi);
                    chk("lo8", {24'b0, lo8}, e.lo);
                    chk("busy8", bc8, e.busy);
                end
                bc8 = 0;
            end
            pd8 = done8;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic issue_op(input bit w8, input logic [1:0] op, input logic [5:0] f,
                            input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        alu_op = op; funct = f;
        if (w8) begin rs8 = a[7:0]; rt8 = b[7:0]; issue8 = 1'b1; end
        else    begin rs  = a;      rt  = b;      issue  = 1'b1; end
        @(posedge clk); #1;
        issue = 1'b0; issue8 = 1'b0;
    endtask

    task automatic wait_idle(input bit w8);
        bit ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (w8 ? (!busy8 && !done8) : (!busy && !done)) begin
                ok = 1'b1;
                break;
            end
        end
        chk(w8 ? "wait_idle8" : "wait_idle32", {31'b0, ok}, 32'd1);
    endtask

    task automatic run_md(input bit w8, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
        exp_t e;
        e.hi = ehi; e.lo = elo; e.busy = w8 ? 9 : 33;
        if (w8) q8.push_back(e); else q32.push_back(e);
        issue_op(w8, 2'b10, f, a, b);
        wait_idle(w8);
    endtask

    task automatic dec(input logic [1:0] op, input logic [5:0] f, input logic [3:0] exp);
        alu_op = op; funct = f; issue = 1'b1;
        #1;
        chk("decode", {28'b0, ctrl}, {28'b0, exp});
        chk("decode_stall", {31'b0, stall}, 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        exp_t e;
        reset = 1'b1; issue = 1'b0; issue8 = 1'b0;
        alu_op = 2'b00; funct = 6'b0; rs = '0; rt = '0; rs8 = '0; rt8 = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_busy8", {31'b0, busy8}, 32'd0);

        // decode sweep, all within one cycle
        @(posedge clk); #1;
        dec(2'b10, 6'b101010, 4'b0111);
        dec(2'b00, 6'b101010, 4'b0010);
        dec(2'b01, 6'b101010, 4'b0110);
        dec(2'b11, 6'b101010, 4'b0001);
        dec(2'b10, 6'b100111, 4'b1100);
        dec(2'b10, 6'b111111, 4'b0000);
        dec(2'b10, 6'b000011, 4'b1010);
        issue = 1'b0;

        // multiply
        run_md(0, 6'b011000, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB);
        run_md(0, 6'b011001, 32'hFFFFFFFD, 32'h00000007, 32'h00000006, 32'hFFFFFFEB);
        // divide
        run_md(0, 6'b011011, 32'd100,      32'd7,        32'h00000002, 32'h0000000E);
        run_md(0, 6'b011010, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_md(0, 6'b011010, 32'd5,        32'd0,        32'h00000005, 32'hFFFFFFFF);
        run_md(0, 6'b011010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);

        // stall interlock: mflo, a non-MD op, then a mult during RUN
        e.hi = 32'h0; e.lo = 32'h00010000; e.busy = 33;
        q32.push_back(e);
        issue_op(0, 2'b10, 6'b011000, 32'h00001000, 32'h00000010);
        alu_op = 2'b10; funct = 6'b010010; rs = 32'd5; rt = 32'd5; issue = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_mflo", {31'b0, stall}, 32'd1);
        end
        alu_op = 2'b00; funct = 6'b100000;
        #1 chk("stall_nonmd", {31'b0, stall}, 32'd0);
        alu_op = 2'b10; funct = 6'b011000;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!busy) break;
            chk("stall_mult", {31'b0, stall}, 32'd1);
        end
        issue = 1'b0;
        chk("stall_phase_end", {31'b0, busy}, 32'd0);
        wait_idle(0);

        // mtlo / mthi
        issue_op(0, 2'b10, 6'b010011, 32'h00001234, 32'h0);
        chk("mtlo_lo", lo, 32'h00001234);
        chk("mtlo_done", {31'b0, done}, 32'd0);
        chk("mtlo_hi_kept", hi, 32'h0);
        issue_op(0, 2'b10, 6'b010001, 32'h0000ABCD, 32'h0);
        chk("mthi_hi", hi, 32'h0000ABCD);
        chk("mthi_lo_kept", lo, 32'h00001234);

        // reset during RUN
        issue_op(0, 2'b10, 6'b011000, 32'd7, 32'd9);
        repeat (9) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        reset = 1'b0;
        run_md(0, 6'b011000, 32'd3, 32'd4, 32'h0, 32'h0000000C);

        // WIDTH=8 instance
        run_md(1, 6'b011000, 32'hFD, 32'h07, 32'hFF, 32'hEB);
        run_md(1, 6'b011001, 32'hFD, 32'h07, 32'h06, 32'hEB);
        run_md(1, 6'b011011, 32'd100, 32'd7, 32'h02, 32'h0E);
        run_md(1, 6'b011010, 32'hF9, 32'h02, 32'hFF, 32'hFD);
        run_md(1, 6'b011010, 32'd5,  32'd0,  32'h05, 32'hFF);
        run_md(1, 6'b011010, 32'h80, 32'hFF, 32'h00, 32'h80);

        repeat (2) @(negedge clk);
        chk("sb32_drained", 32'(q32.size()), 32'd0);
        chk("sb8_drained", 32'(q8.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
